param_register_file: RTL

Parametrised successor to the datapath register file in the multicore processor. It holds the special registers (AR, DR, PC, IR, AC) and NUM_GPR general registers, each DATA_W bits wide. It connects to a shared B-bus, to the instruction and data memory interfaces, and to the ALU operand latches. New in this generation: generic register count and width, per-register increment with wrap or saturate mode, wrap-event flags, and a defined priority for every simultaneous-event case.

---
 rtl/param_register_file.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/param_register_file.sv
// param_register_file
//   Datapath register file: special registers AR, DR, PC, IR and AC, plus
//   NUM_GPR general registers R1..R[NUM_GPR]. Every register is DATA_W bits.
//   It sits on the shared B-bus, feeds the instruction and data memory ports,
//   and loads the two ALU operand latches.
//
//   Select codes: 0=AR 1=DR 2=PC 3=IR 4=AC, 5+k=R(k+1). Higher codes are
//   unmapped: writes to them are ignored and reads of them return 0.
//
// Ports
//   clk, rst_n       rising-edge clock, asynchronous active-low reset
//   bus_in           B-bus write data
//   ins_in           instruction memory data (the only IR write source)
//   din              data memory read data, loaded into DR on mem_read
//   mem_read         load DR from din (wins over a bus write to DR)
//   wr_en, wr_sel    bus write strobe and destination code
//   rd_en, rd_sel    bus read enable and source code (bus_out is combinational)
//   rst_mask         per-GPR synchronous clear, bit i-1 = Ri
//   inc_mask         per-GPR increment, bit i-1 = Ri
//   pc_inc           PC increment (a PC write wins)
//   ld_a             latch AC into alu_a
//   ld_b, b_src      latch the register selected by b_src into alu_b
//   bus_out          B-bus read data
//   alu_a, alu_b     ALU operand latches
//   ir_out, dm_addr, im_addr, dout   continuous copies of IR, AR, PC, DR
//   inc_wrap         one-cycle wrap/saturate flags, bit i-1 = Ri, bit NUM_GPR = PC
module param_register_file #(
  parameter int DATA_W  = 16,
  parameter int NUM_GPR = 7,
  parameter int SEL_W   = 4,
  parameter int INC_SAT = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DATA_W-1:0]  bus_in,
  input  logic [DATA_W-1:0]  ins_in,
  input  logic [DATA_W-1:0]  din,
  input  logic               mem_read,
  input  logic               wr_en,
  input  logic [SEL_W-1:0]   wr_sel,
  input  logic               rd_en,
  input  logic [SEL_W-1:0]   rd_sel,
  input  logic [NUM_GPR-1:0] rst_mask,
  input  logic [NUM_GPR-1:0] inc_mask,
  input  logic               pc_inc,
  input  logic               ld_a,
  input  logic               ld_b,
  input  logic [SEL_W-1:0]   b_src,
  output logic [DATA_W-1:0]  bus_out,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [DATA_W-1:0]  ir_out,
  output logic [DATA_W-1:0]  dm_addr,
  output logic [DATA_W-1:0]  im_addr,
  output logic [DATA_W-1:0]  dout,
  output logic [NUM_GPR:0]   inc_wrap
);

  localparam logic [SEL_W-1:0]  SEL_AR = SEL_W'(0);
  localparam logic [SEL_W-1:0]  SEL_DR = SEL_W'(1);
  localparam logic [SEL_W-1:0]  SEL_PC = SEL_W'(2);
  localparam logic [SEL_W-1:0]  SEL_IR = SEL_W'(3);
  localparam logic [SEL_W-1:0]  SEL_AC = SEL_W'(4);
  localparam logic [DATA_W-1:0] ONE    = DATA_W'(1);

  logic [DATA_W-1:0] ar, dr, pc, ir, ac;
  logic [DATA_W-1:0] gpr [NUM_GPR];

  logic [NUM_GPR-1:0] wr_gpr;
  logic               wr_ar, wr_dr, wr_pc, wr_ir, wr_ac;
  logic [NUM_GPR:0]   wrap_next;
  logic [DATA_W-1:0]  rd_value;
  logic [DATA_W-1:0]  b_value;

  // +1 step: an all-ones value either wraps to zero or holds, by mode.
  function automatic logic [DATA_W-1:0] inc_step(input logic [DATA_W-1:0] v);
    if (&v) return (INC_SAT != 0) ? v : '0;
    return v + ONE;
  endfunction

  // Register contents for a select code; unmapped codes give zero.
  function automatic logic [DATA_W-1:0] reg_value(input logic [SEL_W-1:0] s);
    logic [DATA_W-1:0] v;
    v = '0;
    if (s == SEL_AR)      v = ar;
    else if (s == SEL_DR) v = dr;
    else if (s == SEL_PC) v = pc;
    else if (s == SEL_IR) v = ir;
    else if (s == SEL_AC) v = ac;
    else begin
      for (int k = 0; k < NUM_GPR; k++) begin
        if (s == SEL_W'(5 + k)) v = gpr[k];
      end
    end
    return v;
  endfunction

  // Write decode; unmapped codes match nothing and are dropped.
  always_comb begin
    wr_ar = wr_en && (wr_sel == SEL_AR);
    wr_dr = wr_en && (wr_sel == SEL_DR);
    wr_pc = wr_en && (wr_sel == SEL_PC);
    wr_ir = wr_en && (wr_sel == SEL_IR);
    wr_ac = wr_en && (wr_sel == SEL_AC);
    for (int k = 0; k < NUM_GPR; k++) begin
      wr_gpr[k] = wr_en && (wr_sel == SEL_W'(5 + k));
    end
  end

  // A wrap flag is raised only when the increment actually takes effect,
  // i.e. it was not pre-empted by a clear or a write to the same register.
  always_comb begin
    wrap_next = '0;
    for (int k = 0; k < NUM_GPR; k++) begin
      wrap_next[k] = inc_mask[k] && !rst_mask[k] && !wr_gpr[k] && (&gpr[k]);
    end
    wrap_next[NUM_GPR] = pc_inc && !wr_pc && (&pc);
  end

  always_comb begin
    rd_value = reg_value(rd_sel);
    b_value  = reg_value(b_src);
  end

  assign bus_out = rd_en ? rd_value : '0;
  assign ir_out  = ir;
  assign dm_addr = ar;
  assign im_addr = pc;
  assign dout    = dr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar       <= '0;
      dr       <= '0;
      pc       <= '0;
      ir       <= '0;
      ac       <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      inc_wrap <= '0;
      for (int k = 0; k < NUM_GPR; k++) gpr[k] <= '0;
    end else begin
      if (wr_ar) ar <= bus_in;
      if (mem_read)   dr <= din;
      else if (wr_dr) dr <= bus_in;
      if (wr_pc)       pc <= bus_in;
      else if (pc_inc) pc <= inc_step(pc);
      // IR is loaded from the instruction memory, never from the B-bus.
      if (wr_ir) ir <= ins_in;
      if (wr_ac) ac <= bus_in;
      for (int k = 0; k < NUM_GPR; k++) begin
        if (rst_mask[k])      gpr[k] <= '0;
        else if (wr_gpr[k])   gpr[k] <= bus_in;
        else if (inc_mask[k]) gpr[k] <= inc_step(gpr[k]);
      end
      // Operand latches sample the pre-edge register values.
      if (ld_a) alu_a <= ac;
      if (ld_b) alu_b <= b_value;
      inc_wrap <= wrap_next;
    end
  end

endmodule
